// File: rtl/temp3w_pkg.sv
// Shared types and timing constants for the 3-wire temperature sensor controller.
package temp3w_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        READ,
        TURN,
        WRITE,
        CS_HOLD
    } state_t;

    // One extra bit so the counter can also reach DATA_W plus the trailing half-period.
    function automatic int bit_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int BIT_CNT_W = bit_cnt_w(16);

    localparam int SETUP_HP = 1;
    localparam int TRAIL_HP = 1;
    localparam int TURN_HP  = 1;
    localparam int HOLD_HP  = 2;

endpackage

// File: rtl/temp3w_if.sv
// CPU-side request/status and split sensor pad signals of the temperature sensor controller.
interface temp3w_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic              auto_en;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] temp_data;
    logic              temp_valid;
    logic              cs_n;
    logic              sc;
    logic              sio_o;
    logic              sio_oe;
    logic              sio_i;

    modport master (
        input  start, auto_en, wr_en, wr_data, sio_i,
        output busy, done, temp_data, temp_valid, cs_n, sc, sio_o, sio_oe
    );

    modport slave (
        output start, auto_en, wr_en, wr_data, sio_i,
        input  busy, done, temp_data, temp_valid, cs_n, sc, sio_o, sio_oe
    );

endinterface

// File: rtl/temp3w_tick_gen.sv
// Half-period tick generator: one tick every CLK_DIV enabled cycles.
module temp3w_tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk_50,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/temp3w_sensor_ctrl.sv
// Master sequencer for the 3-wire temperature sensor: read a word, optionally write a
// command word, triggered by a CPU start pulse or the internal poll timer.
module temp3w_sensor_ctrl
    import temp3w_pkg::*;
#(
    parameter int CLK_DIV     = 25,
    parameter int POLL_CYCLES = 50000000,
    parameter int DATA_W      = 16
) (
    input  logic     clk_50,
    input  logic     reset_n,
    temp3w_if.master bus
);
    localparam int BCW = bit_cnt_w(DATA_W);
    localparam int PW  = $clog2(POLL_CYCLES);

    localparam logic [BCW-1:0] SETUP_LAST = BCW'(SETUP_HP - 1);
    localparam logic [BCW-1:0] TURN_LAST  = BCW'(TURN_HP - 1);
    localparam logic [BCW-1:0] HOLD_LAST  = BCW'(HOLD_HP - 1);
    localparam logic [BCW-1:0] BITS       = BCW'(DATA_W);
    localparam logic [BCW-1:0] LAST_BIT   = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0] TRAIL_LAST = BCW'(DATA_W + TRAIL_HP - 1);
    localparam logic [PW-1:0]  POLL_LAST  = PW'(POLL_CYCLES - 1);

    state_t            state, state_nxt;
    logic              hp_tick;
    logic              phase;
    logic [BCW-1:0]    bit_cnt;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] wr_shift;
    logic              wr_sel;
    logic              pending;
    logic [PW-1:0]     poll_cnt;
    logic              poll_tick;
    logic              req_in;
    logic              accept;
    logic [DATA_W-1:0] temp_data;
    logic              temp_valid;
    logic              done;

    logic setup_end, read_done, turn_end, write_done, hold_end;

    temp3w_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .en      (state != IDLE),
        .clr     (accept),
        .tick    (hp_tick)
    );

    // Poll timer runs regardless of busy; requests landing mid-transfer become pending.
    assign poll_tick = bus.auto_en && (poll_cnt == POLL_LAST);
    assign req_in    = bus.start || poll_tick;
    assign accept    = (state == IDLE) && (req_in || pending);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt <= '0;
        end else if (!bus.auto_en || poll_tick) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
        end else if (accept) begin
            pending <= 1'b0;
        end else if (state != IDLE && req_in) begin
            pending <= 1'b1;
        end
    end

    assign setup_end  = (state == CS_SETUP) && hp_tick && (bit_cnt == SETUP_LAST);
    assign read_done  = (state == READ) && hp_tick && !phase && (bit_cnt == TRAIL_LAST);
    assign turn_end   = (state == TURN) && hp_tick && (bit_cnt == TURN_LAST);
    assign write_done = (state == WRITE) && hp_tick && phase && (bit_cnt == LAST_BIT);
    assign hold_end   = (state == CS_HOLD) && hp_tick && (bit_cnt == HOLD_LAST);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept)     state_nxt = CS_SETUP;
            CS_SETUP: if (setup_end)  state_nxt = READ;
            READ:     if (read_done)  state_nxt = wr_sel ? TURN : CS_HOLD;
            TURN:     if (turn_end)   state_nxt = WRITE;
            WRITE:    if (write_done) state_nxt = CS_HOLD;
            CS_HOLD:  if (hold_end)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Pad outputs decode straight from registered state so reset releases the bus at once.
    always_comb begin
        bus.busy   = (state != IDLE);
        bus.cs_n   = (state == IDLE) || (state == CS_HOLD);
        bus.sc     = ((state == READ) || (state == WRITE)) && phase;
        bus.sio_oe = (state == WRITE);
        bus.sio_o  = (state == WRITE) && wr_shift[DATA_W-1];
    end

    // bit_cnt counts bits in READ/WRITE (advancing on sc falling) and half-periods elsewhere.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            phase   <= 1'b0;
        end else if (state_nxt != state) begin
            bit_cnt <= '0;
            phase   <= 1'b0;
        end else if (hp_tick) begin
            if (state == READ || state == WRITE) begin
                if (phase || bit_cnt >= BITS) begin
                    bit_cnt <= bit_cnt + BCW'(1);
                end
                phase <= !phase && (bit_cnt < BITS);
            end else begin
                bit_cnt <= bit_cnt + BCW'(1);
            end
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            rd_shift   <= '0;
            wr_shift   <= '0;
            wr_sel     <= 1'b0;
            temp_data  <= '0;
            temp_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= hold_end;
            if (accept) begin
                wr_sel   <= bus.wr_en;
                wr_shift <= bus.wr_data;
            end else if (state == WRITE && hp_tick && phase) begin
                wr_shift <= {wr_shift[DATA_W-2:0], 1'b0};
            end
            if (state == READ && hp_tick && !phase && bit_cnt < BITS) begin
                rd_shift <= {rd_shift[DATA_W-2:0], bus.sio_i};
            end
            if (read_done) begin
                temp_data  <= rd_shift;
                temp_valid <= 1'b1;
            end
        end
    end

    assign bus.temp_data  = temp_data;
    assign bus.temp_valid = temp_valid;
    assign bus.done       = done;

endmodule

// File: tb/tb_temp3w_sensor_ctrl.sv
// Bench for temp3w_sensor_ctrl: sensor model, pin monitor and a scoreboard of transfers.
module tb_temp3w_sensor_ctrl;
    localparam int CLK_DIV = 2;
    localparam int POLL    = 400;
    localparam int DW      = 16;

    typedef struct {
        logic        wr_en;
        logic [15:0] wr_data;
        logic [15:0] sens;
        logic [15:0] exp_temp;
        int          exp_cs_low;
        int          exp_wr_rises;
        int          exp_oe;
    } vec_t;

    logic clk_50  = 1'b0;
    logic reset_n = 1'b0;

    temp3w_if #(.DATA_W(DW)) bus ();

    temp3w_sensor_ctrl #(
        .CLK_DIV     (CLK_DIV),
        .POLL_CYCLES (POLL),
        .DATA_W      (DW)
    ) dut (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #10 clk_50 = ~clk_50;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Sensor model: presents MSB when selected, advances on each sc falling edge.
    logic [15:0] sens_word = 16'h0000;
    logic [3:0]  sens_idx  = 4'd15;
    assign bus.sio_i = sens_word[sens_idx];

    int          cyc = 0, n_xfers = 0, n_done = 0;
    int          cs_low_cnt = 0, cs_high_cnt = 0, last_cs_low = 0, last_gap = 0;
    int          rd_rises = 0, wr_rises = 0, oe_cnt = 0, oe_bad = 0;
    logic [15:0] wr_cap = 16'h0000;
    logic        prev_cs = 1'b1, prev_sc = 1'b0;
    int          fall_q[$];
    vec_t        sb[$];

    always @(negedge clk_50) begin
        vec_t e;
        cyc++;
        if (prev_cs && !bus.cs_n) begin
            n_xfers++;
            fall_q.push_back(cyc);
            last_gap   = cs_high_cnt;
            cs_low_cnt = 0;
            rd_rises   = 0;
            wr_rises   = 0;
            oe_cnt     = 0;
            sens_idx   = 4'd15;
        end
        if (!prev_cs && bus.cs_n) begin
            last_cs_low = cs_low_cnt;
            cs_high_cnt = 0;
        end
        if (!bus.cs_n) cs_low_cnt++;
        else           cs_high_cnt++;
        if (!prev_sc && bus.sc) begin
            if (bus.sio_oe) begin
                wr_cap = {wr_cap[14:0], bus.sio_o};
                wr_rises++;
            end else begin
                rd_rises++;
            end
        end
        if (prev_sc && !bus.sc && sens_idx != 4'd0) sens_idx--;
        if (bus.sio_oe) oe_cnt++;
        if (bus.sio_oe && bus.cs_n) oe_bad++;
        if (bus.done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("temp_data", bus.temp_data, e.exp_temp);
                check("temp_valid", bus.temp_valid, 1);
                check("busy_at_done", bus.busy, 0);
                check("cs_low_cycles", last_cs_low, e.exp_cs_low);
                check("read_sc_rises", rd_rises, 16);
                check("write_sc_rises", wr_rises, e.exp_wr_rises);
                check("sio_oe_cycles", oe_cnt, e.exp_oe);
                if (e.wr_en) check("write_word", wr_cap, e.wr_data);
            end
        end
        prev_cs = bus.cs_n;
        prev_sc = bus.sc;
    end

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (n_done < target && n < budget) begin
            @(negedge clk_50);
            n++;
        end
        if (n_done < target) check("done_timeout", n_done, target);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk_50);
        bus.start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    vec_t        vec[5];
    vec_t        r;
    logic [15:0] prev_temp;
    logic        prev_valid;
    int          base_x, base_d, n;

    initial begin
        bus.start   = 1'b0;
        bus.auto_en = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 16'h0000;

        vec[0] = '{1'b0, 16'h0000, 16'h1A3C, 16'h1A3C, 68, 0, 0};
        vec[1] = '{1'b1, 16'hFFFF, 16'h0C80, 16'h0C80, 134, 16, 64};
        vec[2] = '{1'b1, 16'hA5C3, 16'h8001, 16'h8001, 134, 16, 64};
        vec[3] = '{1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 68, 0, 0};
        vec[4] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 134, 16, 64};

        #5;
        check("rst_cs_n", bus.cs_n, 1);
        check("rst_sc", bus.sc, 0);
        check("rst_sio_oe", bus.sio_oe, 0);
        check("rst_sio_o", bus.sio_o, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_temp_valid", bus.temp_valid, 0);
        check("rst_temp_data", bus.temp_data, 0);
        repeat (3) @(negedge clk_50);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_50);

        prev_temp  = 16'h0000;
        prev_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sens_word   = vec[i].sens;
            bus.wr_en   = vec[i].wr_en;
            bus.wr_data = vec[i].wr_data;
            sb.push_back(vec[i]);
            base_d = n_done;
            pulse_start();
            bus.wr_en   = 1'b0;
            bus.wr_data = ~vec[i].wr_data;
            check("busy_after_start", bus.busy, 1);
            repeat (20) @(negedge clk_50);
            check("temp_hold_mid", bus.temp_data, prev_temp);
            check("valid_hold_mid", bus.temp_valid, prev_valid);
            wait_done(base_d + 1, 400);
            prev_temp  = vec[i].exp_temp;
            prev_valid = 1'b1;
            repeat (3) @(negedge clk_50);
        end

        // Back-to-back: second start pends, third is absorbed into the same pending slot.
        r = '{1'b0, 16'h0000, 16'h5A5A, 16'h5A5A, 68, 0, 0};
        sens_word = r.sens;
        base_x = n_xfers;
        base_d = n_done;
        sb.push_back(r);
        sb.push_back(r);
        pulse_start();
        repeat (9) @(negedge clk_50);
        pulse_start();
        repeat (10) @(negedge clk_50);
        check("busy_at_third", bus.busy, 1);
        pulse_start();
        wait_done(base_d + 2, 600);
        repeat (300) @(negedge clk_50);
        check("b2b_xfers", n_xfers - base_x, 2);
        check("b2b_dones", n_done - base_d, 2);
        check("b2b_gap_ge4", (last_gap >= 4), 1);

        // Polling: five timer-driven reads at 400-cycle spacing, then silence.
        r = '{1'b0, 16'h0000, 16'h0321, 16'h0321, 68, 0, 0};
        sens_word = r.sens;
        base_x = n_xfers;
        base_d = n_done;
        fall_q.delete();
        for (int k = 0; k < 5; k++) sb.push_back(r);
        bus.auto_en = 1'b1;
        repeat (2000) @(negedge clk_50);
        bus.auto_en = 1'b0;
        wait_done(base_d + 5, 500);
        repeat (1000) @(negedge clk_50);
        check("poll_xfers", n_xfers - base_x, 5);
        check("poll_falls", fall_q.size(), 5);
        if (fall_q.size() == 5) begin
            for (int k = 1; k < 5; k++) check("poll_spacing", fall_q[k] - fall_q[k-1], POLL);
        end

        // Start coinciding with a poll tick counts as a single request.
        r = '{1'b0, 16'h0000, 16'h7E01, 16'h7E01, 68, 0, 0};
        sens_word = r.sens;
        base_x = n_xfers;
        base_d = n_done;
        sb.push_back(r);
        bus.auto_en = 1'b1;
        repeat (399) @(negedge clk_50);
        bus.start = 1'b1;
        @(negedge clk_50);
        bus.start   = 1'b0;
        bus.auto_en = 1'b0;
        wait_done(base_d + 1, 500);
        repeat (500) @(negedge clk_50);
        check("simul_xfers", n_xfers - base_x, 1);

        // Reset asserted in WRITE releases everything asynchronously.
        bus.wr_en   = 1'b1;
        bus.wr_data = 16'h3C3C;
        pulse_start();
        bus.wr_en = 1'b0;
        n = 0;
        while (!bus.sio_oe && n < 300) begin
            @(negedge clk_50);
            n++;
        end
        check("reach_write", bus.sio_oe, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_cs_n", bus.cs_n, 1);
        check("mid_rst_sc", bus.sc, 0);
        check("mid_rst_sio_oe", bus.sio_oe, 0);
        check("mid_rst_sio_o", bus.sio_o, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_temp_valid", bus.temp_valid, 0);
        check("mid_rst_temp_data", bus.temp_data, 0);
        @(negedge clk_50);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_50);
        check("post_rst_cs_n", bus.cs_n, 1);

        check("scoreboard_empty", sb.size(), 0);
        check("oe_outside_cs", oe_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
